// File: rtl/alib_bitstream_packer.sv
// alib_bitstream_packer
//
// Packs bytes from an upstream bit FIFO into DATA_WIDTH-bit AXI-Stream beats.
// Bytes are read one at a time and placed into byte lanes MSB first. A full
// word is emitted as a normal beat. An i_flush pulse ends the frame: the
// partial word, or an empty word, goes out as a beat with tlast set.
//
// Optional feature (macro ALIB_BITSTREAM_PACKER_STUFF_EN): every captured 0xFF
// byte is followed by an inserted 0x00 byte. If 0xFF lands in the last lane,
// the 0x00 goes into lane 0 of the next word before any further FIFO read.
// Without the macro, bytes pass through unmodified and no stuffing logic exists.
//
// Ports
//   i_clk, i_rst           clock (rising edge), synchronous active-low reset
//   o_fifo_rd_en           byte read request; data arrives on the next cycle
//   o_fifo_rd_len          read length in bits, always 8
//   i_fifo_rd_data         FIFO read data, first bitstream bit at bit 7
//   i_fifo_empty           FIFO holds fewer than 8 bits
//   i_fifo_bits_left       FIFO bit count, only looked at when a flush completes
//   i_flush                one-cycle end-of-frame pulse
//   o_m_t*, i_m_tready     AXI-Stream master
//   o_byte_count           wrapping count of emitted bytes, stuffed bytes included
//   o_residue_err          sticky: FIFO still held sub-byte bits at a flush
//   o_busy                 packer has work outstanding
//   o_state                current FSM state (S_FILL=0, S_OUT=1, S_LAST=2)
//
// Handshake: a beat transfers on a rising edge where o_m_tvalid and i_m_tready
// are both high. Once o_m_tvalid rises, o_m_tdata, o_m_tkeep and o_m_tlast stay
// stable and o_m_tvalid stays high until that transfer; o_m_tvalid never
// depends on i_m_tready.

module alib_bitstream_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  output logic                    o_fifo_rd_en,
  output logic [3:0]              o_fifo_rd_len,
  input  logic [7:0]              i_fifo_rd_data,
  input  logic                    i_fifo_empty,
  input  logic [3:0]              i_fifo_bits_left,
  input  logic                    i_flush,
  output logic [DATA_WIDTH-1:0]   o_m_tdata,
  output logic [DATA_WIDTH/8-1:0] o_m_tkeep,
  output logic                    o_m_tvalid,
  output logic                    o_m_tlast,
  input  logic                    i_m_tready,
  output logic [31:0]             o_byte_count,
  output logic                    o_residue_err,
  output logic                    o_busy,
  output logic [1:0]              o_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_OUT  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] word, word_nxt;
  logic [NB-1:0]         keep, keep_nxt;
  logic [LW-1:0]         lane, lane_nxt;
  logic                  rd_inflight;
  logic                  flush_req, flush_req_nxt;
  logic                  stuff_pend;
  logic                  rd_req;
  logic                  fill;
  logic                  stuff_now;
  logic                  handshake;
  logic                  enter_last;
  logic [7:0]            fill_byte;
  logic [31:0]           keep_pop;
  logic [31:0]           byte_count;
  logic                  residue_err;

  // Next-state and datapath decode.
  always_comb begin
    state_nxt  = state;
    rd_req     = 1'b0;
    handshake  = 1'b0;
    enter_last = 1'b0;
    word_nxt   = word;
    keep_nxt   = keep;
    lane_nxt   = lane;

    // A byte lands in the word either from a completed FIFO read or from a
    // pending stuff byte; reads are blocked while stuffing, so never both.
    stuff_now = (state == S_FILL) && stuff_pend && !rd_inflight;
    fill      = (state == S_FILL) && (rd_inflight || stuff_now);
    fill_byte = rd_inflight ? i_fifo_rd_data : 8'h00;

    case (state)
      S_FILL: begin
        rd_req = !i_fifo_empty && !rd_inflight && !stuff_pend && !flush_req;
        if (fill && (lane == LW'(NB - 1))) begin
          state_nxt = S_OUT;
        end else if (flush_req && !rd_inflight && !stuff_pend && i_fifo_empty) begin
          state_nxt  = S_LAST;
          enter_last = 1'b1;
        end
      end
      S_OUT, S_LAST: begin
        if (i_m_tready) begin
          state_nxt = S_FILL;
          handshake = 1'b1;
        end
      end
      default: state_nxt = S_FILL;
    endcase

    if (handshake) begin
      word_nxt = '0;
      keep_nxt = '0;
      lane_nxt = '0;
    end else if (fill) begin
      for (int i = 0; i < NB; i++) begin
        if (lane == LW'(i)) begin
          word_nxt[DATA_WIDTH-1-8*i -: 8] = fill_byte;
          keep_nxt[NB-1-i]                = 1'b1;
        end
      end
      lane_nxt = lane + LW'(1);
    end

    // A pulse that coincides with the end of the previous frame belongs to
    // the next frame, so it is kept rather than cleared.
    if (handshake && (state == S_LAST)) begin
      flush_req_nxt = i_flush;
    end else begin
      flush_req_nxt = flush_req | i_flush;
    end
  end

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < NB; i++) begin
      keep_pop = keep_pop + 32'(keep[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= S_FILL;
      word        <= '0;
      keep        <= '0;
      lane        <= '0;
      rd_inflight <= 1'b0;
      flush_req   <= 1'b0;
      byte_count  <= '0;
      residue_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      word        <= word_nxt;
      keep        <= keep_nxt;
      lane        <= lane_nxt;
      rd_inflight <= rd_req;
      flush_req   <= flush_req_nxt;
      if (handshake) begin
        byte_count <= byte_count + keep_pop;
      end
      if (enter_last && (i_fifo_bits_left != 4'd0)) begin
        residue_err <= 1'b1;
      end
    end
  end

`ifdef ALIB_BITSTREAM_PACKER_STUFF_EN
  // Set when an 0xFF byte is captured; cleared once its 0x00 follower is in.
  // Survives the S_OUT phase when 0xFF filled the last lane.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      stuff_pend <= 1'b0;
    end else if (fill && rd_inflight && (i_fifo_rd_data == 8'hFF)) begin
      stuff_pend <= 1'b1;
    end else if (stuff_now) begin
      stuff_pend <= 1'b0;
    end
  end
`else
  assign stuff_pend = 1'b0;
`endif

  // Stream outputs are forced low while reset is held so nothing leaks out
  // before the first reset edge.
  assign o_fifo_rd_en  = rd_req & i_rst;
  assign o_fifo_rd_len = 4'd8;
  assign o_m_tvalid    = i_rst && (state != S_FILL);
  assign o_m_tlast     = i_rst && (state == S_LAST);
  assign o_m_tdata     = i_rst ? word : '0;
  assign o_m_tkeep     = i_rst ? keep : '0;
  assign o_byte_count  = byte_count;
  assign o_residue_err = residue_err;
  assign o_busy        = (state != S_FILL) || (lane != '0) || rd_inflight ||
                         stuff_pend || flush_req;
  assign o_state       = state;

endmodule

// File: tb/tb_alib_bitstream_packer.sv
module tb_alib_bitstream_packer;

  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          fifo_rd_en;
  logic [3:0]    fifo_rd_len;
  logic [7:0]    fifo_rd_data;
  logic          fifo_empty;
  logic [3:0]    bits_left = 4'd0;
  logic          flush = 1'b0;
  logic [DW-1:0] tdata;
  logic [3:0]    tkeep;
  logic          tvalid;
  logic          tlast;
  logic          tready = 1'b1;
  logic [31:0]   byte_count;
  logic          residue_err;
  logic          busy;
  logic [1:0]    state;

  alib_bitstream_packer #(.DATA_WIDTH(DW)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_fifo_rd_en     (fifo_rd_en),
    .o_fifo_rd_len    (fifo_rd_len),
    .i_fifo_rd_data   (fifo_rd_data),
    .i_fifo_empty     (fifo_empty),
    .i_fifo_bits_left (bits_left),
    .i_flush          (flush),
    .o_m_tdata        (tdata),
    .o_m_tkeep        (tkeep),
    .o_m_tvalid       (tvalid),
    .o_m_tlast        (tlast),
    .i_m_tready       (tready),
    .o_byte_count     (byte_count),
    .o_residue_err    (residue_err),
    .o_busy           (busy),
    .o_state          (state)
  );

  // ---------------- upstream FIFO model ----------------
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_rd_data <= fifo_mem[rd_ptr[7:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b);
    fifo_mem[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    bits_left = 4'd0;
    step();
    step();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_tkeep", 64'(tkeep), 64'd0);
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_byte_count", 64'(byte_count), 64'd0);
    chk("rst_residue", 64'(residue_err), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    rst = 1'b1;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rd_len", 64'(fifo_rd_len), 64'd8);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!tvalid && n < 100) begin
      step();
      n++;
    end
    if (!tvalid) begin
      checks++;
      errors++;
      $display("FAIL %s: tvalid timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_drained(input string name);
    int n;
    n = 0;
    while ((rd_ptr != wr_ptr) && n < 100) begin
      step();
      n++;
    end
    if (rd_ptr != wr_ptr) begin
      checks++;
      errors++;
      $display("FAIL %s: fifo drain timeout got %0d expected %0d", name, rd_ptr, wr_ptr);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [31:0] bytes;
    bit          do_flush;
    logic [3:0]  bl;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
    bit          exp_last;
    logic [31:0] exp_bc;
    bit          exp_res;
  } vec_t;

  vec_t vecs[8];
  int   nv = 0;

  task automatic add_vec(input int n, input logic [31:0] bytes, input bit f,
                         input logic [3:0] bl, input logic [31:0] d,
                         input logic [3:0] k, input bit l,
                         input logic [31:0] bc, input bit r);
    vecs[nv].n        = n;
    vecs[nv].bytes    = bytes;
    vecs[nv].do_flush = f;
    vecs[nv].bl       = bl;
    vecs[nv].exp_data = d;
    vecs[nv].exp_keep = k;
    vecs[nv].exp_last = l;
    vecs[nv].exp_bc   = bc;
    vecs[nv].exp_res  = r;
    nv++;
  endtask

  logic [31:0] held;

  initial begin
    //       n  bytes         flush bl    tdata         keep  last bc  res
    add_vec(4, 32'h12345678, 0, 4'd0, 32'h12345678, 4'hF, 0, 32'd4,  0);
    add_vec(2, 32'hAABB0000, 1, 4'd0, 32'hAABB0000, 4'hC, 1, 32'd6,  0);
    add_vec(4, 32'hDEADBEEF, 0, 4'd0, 32'hDEADBEEF, 4'hF, 0, 32'd10, 0);
    add_vec(1, 32'h5A000000, 1, 4'd0, 32'h5A000000, 4'h8, 1, 32'd11, 0);
    add_vec(3, 32'h01020300, 1, 4'd0, 32'h01020300, 4'hE, 1, 32'd14, 0);
    add_vec(0, 32'h00000000, 1, 4'd3, 32'h00000000, 4'h0, 1, 32'd14, 1);
    add_vec(4, 32'h11223344, 0, 4'd0, 32'h11223344, 4'hF, 0, 32'd18, 1);

    do_reset();

    // ---- table-driven beats ----
    for (int v = 0; v < nv; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        push_byte(vecs[v].bytes[31-8*k -: 8]);
      end
      if (vecs[v].do_flush) begin
        wait_drained("vec_drain");
        bits_left = vecs[v].bl;
        pulse_flush();
      end
      wait_valid("vec_valid");
      chk("vec_tdata", 64'(tdata), 64'(vecs[v].exp_data));
      chk("vec_tkeep", 64'(tkeep), 64'(vecs[v].exp_keep));
      chk("vec_tlast", 64'(tlast), 64'(vecs[v].exp_last));
      step();
      bits_left = 4'd0;
      chk("vec_byte_count", 64'(byte_count), 64'(vecs[v].exp_bc));
      chk("vec_residue", 64'(residue_err), 64'(vecs[v].exp_res));
    end

    // ---- back-pressure in S_OUT, flush pulse during a stall ----
    do_reset();
    tready = 1'b0;
    push_byte(8'hC0); push_byte(8'hC1); push_byte(8'hC2); push_byte(8'hC3);
    push_byte(8'hD0); push_byte(8'hD1);
    wait_valid("stall1_valid");
    chk("stall1_tdata", 64'(tdata), 64'h00000000C0C1C2C3);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("stall1_hold_tdata", 64'(tdata), 64'h00000000C0C1C2C3);
      chk("stall1_hold_valid", 64'(tvalid), 64'd1);
      chk("stall1_no_rd", 64'(fifo_rd_en), 64'd0);
    end
    tready = 1'b1;
    step();
    tready = 1'b0;
    chk("stall1_byte_count", 64'(byte_count), 64'd4);
    push_byte(8'hE0); push_byte(8'hE1);
    wait_valid("stall2_valid");
    chk("stall2_tdata", 64'(tdata), 64'h00000000D0D1E0E1);
    chk("stall2_tlast", 64'(tlast), 64'd0);
    pulse_flush();
    for (int c = 0; c < 10; c++) begin
      step();
      chk("stall2_hold_tdata", 64'(tdata), 64'h00000000D0D1E0E1);
      chk("stall2_hold_tlast", 64'(tlast), 64'd0);
      chk("stall2_no_rd", 64'(fifo_rd_en), 64'd0);
    end
    tready = 1'b1;
    step();
    wait_valid("stall2_flush_valid");
    chk("stall2_flush_tlast", 64'(tlast), 64'd1);
    chk("stall2_flush_tkeep", 64'(tkeep), 64'd0);
    chk("stall2_flush_tdata", 64'(tdata), 64'd0);
    step();
    chk("stall2_byte_count", 64'(byte_count), 64'd8);
    chk("stall2_tvalid_low", 64'(tvalid), 64'd0);
    chk("stall2_idle", 64'(busy), 64'd0);

    // ---- 0xFF handling ----
    do_reset();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03); push_byte(8'hFF);
    push_byte(8'h04);
    wait_valid("ff_valid1");
    chk("ff_beat1_tdata", 64'(tdata), 64'h00000000010203FF);
    chk("ff_beat1_tkeep", 64'(tkeep), 64'hF);
    chk("ff_beat1_tlast", 64'(tlast), 64'd0);
    step();
    wait_drained("ff_drain");
    pulse_flush();
    wait_valid("ff_valid2");
`ifdef ALIB_BITSTREAM_PACKER_STUFF_EN
    held = tdata;
    chk("stuff_beat2_hi", 64'(held[31:16]), 64'h0004);
    chk("stuff_beat2_tkeep", 64'(tkeep), 64'hC);
    chk("stuff_beat2_tlast", 64'(tlast), 64'd1);
    step();
    chk("stuff_byte_count", 64'(byte_count), 64'd6);
`else
    chk("ff_beat2_tdata", 64'(tdata), 64'h0000000004000000);
    chk("ff_beat2_tkeep", 64'(tkeep), 64'h8);
    chk("ff_beat2_tlast", 64'(tlast), 64'd1);
    step();
    chk("ff_byte_count", 64'(byte_count), 64'd5);
`endif

    // ---- reset asserted in the middle of S_OUT ----
    tready = 1'b0;
    push_byte(8'h9A); push_byte(8'hBC); push_byte(8'hDE); push_byte(8'hF0);
    wait_valid("midrst_valid");
    chk("midrst_pre_state", 64'(state), 64'd1);
    rst = 1'b0;
    step();
    chk("midrst_tvalid", 64'(tvalid), 64'd0);
    chk("midrst_tkeep", 64'(tkeep), 64'd0);
    chk("midrst_byte_count", 64'(byte_count), 64'd0);
    chk("midrst_state", 64'(state), 64'd0);
    rst = 1'b1;
    tready = 1'b1;
    step();
    chk("midrst_tvalid_after", 64'(tvalid), 64'd0);
    chk("midrst_busy_after", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Overall watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time got 200000 expected less");
    $fatal(1);
  end

endmodule
